verifica_senha_multi: RTL and testbench
=======================================

// Module: verifica_senha_multi
// PURPOSE
//  Next-generation password checker for the electronic lock. It compares one typed digit sequence against
//  NUM_SENHAS stored passwords of variable length (MIN_DIG..MAX_DIG) and accepts a stored password found
//  anywhere in the typed sequence (sliding window). It counts consecutive failures and enforces a timed
//  lockout. It sits between the keypad digit packer and the lock-control FSM.
// PARAMETERS
//  MAX_DIG      20   digits per sequence; each digit is 4 bits; 4'hF = empty/terminator
//  NUM_SENHAS   4    number of stored-password slots (>=1)
//  MIN_DIG      4    minimum valid stored-password length
//  MAX_FALHAS   3    consecutive failures that trigger lockout (>=1)
//  BLOQ_CICLOS  1000 lockout duration in clk cycles (>=1)
// PORTS
//  clk           in   1                    system clock, rising edge
//  rst           in   1                    asynchronous reset, active-low (asserted when 0)
//  valid_in      in   1                    1-cycle pulse: new sequence to check
//  senha_teste   in   4*MAX_DIG            typed sequence; digit i = bits[4i+3:4i]
//  senhas_reais  in   NUM_SENHAS*4*MAX_DIG stored passwords; slot s occupies bits [s*4*MAX_DIG +: 4*MAX_DIG]
//  slot_en       in   NUM_SENHAS           slot s participates when bit s = 1
//  busy          out  1                    check in progress (any state other than IDLE and BLOQUEADO)
//  done          out  1                    1-cycle pulse: verdict available
//  senha_ok      out  1                    1 with done = accepted; 0 otherwise
//  match_idx     out  max(1,$clog2(NUM_SENHAS))  matching slot; valid while done && senha_ok
//  bloqueado     out  1                    lockout active
//  falhas        out  $clog2(MAX_FALHAS+1) consecutive-failure count
// BEHAVIOUR
//  Reset (rst=0, asynchronous): state=IDLE; busy=done=senha_ok=bloqueado=0; match_idx=0; falhas=0; counters=0.
//  Length: len = index of the first 4'hF digit, or MAX_DIG if there is none. Digits after the first F are ignored.
//  Slot valid = slot_en[s] && len_s>=MIN_DIG && len_s<=len_teste.
//  Capture: valid_in in IDLE latches senha_teste, senhas_reais and slot_en. Inputs may change afterwards.
//   valid_in in any other state (including BLOQUEADO) is dropped: no done and no counter change.
//  FSM (Moore outputs, decoded from registered state):
//   IDLE      -> DIMENSAO on valid_in; slot=0.
//   DIMENSAO  computes len_s for the current slot and sets off=0. Slot valid -> BUSCA. Slot invalid -> PROXIMA.
//   BUSCA     1 window per cycle: match if teste[off+k]==real_s[k] for all k<len_s.
//             Match -> CORRETA, match_idx=slot. No match with off<len_teste-len_s -> off+1, stay.
//             No match otherwise -> PROXIMA.
//   PROXIMA   slot<NUM_SENHAS-1 -> slot+1, DIMENSAO. Otherwise -> INCORRETA.
//   CORRETA   done=1, senha_ok=1; falhas<=0; -> IDLE.
//   INCORRETA done=1, senha_ok=0; falhas+1.
//             Result ==MAX_FALHAS -> BLOQUEADO with timer=BLOQ_CICLOS-1. Otherwise -> IDLE.
//   BLOQUEADO bloqueado=1; timer decrements each cycle. timer==0 -> IDLE with falhas<=0.
//  Slots are scanned in ascending order; the lowest matching slot wins. Windows are scanned at ascending offsets.
//  Latency: a match in slot 0 at offset 0 gives done in the 3rd cycle after the valid_in edge.
//   Worst case: NUM_SENHAS*(MAX_DIG-MIN_DIG+3)+1 cycles.
//  Arithmetic: off+k never exceeds len_teste-1 (the bound is checked before increment). falhas saturates at MAX_FALHAS.
//  An empty test sequence (digit0=F) or an all-disabled slot_en -> INCORRETA, which counts as a failure.
//  Reset mid-check or mid-lockout aborts immediately to the reset values. No done is produced.
// TESTING
//  T1 slot0="1234", teste="1234F..", slot_en=0001, valid_in -> done=1, senha_ok=1, match_idx=0 on cycle 3; falhas=0.
//  T2 slot2="987654", teste="0098765411F..", slot_en=0111 -> done, senha_ok=1, match_idx=2 (offset 2). Check latency count.
//  T3 slot0="123" (len<MIN_DIG), slot1="5555", teste="55555" -> slot0 skipped; match_idx=1.
//  T4 three wrong attempts (MAX_FALHAS=3, BLOQ_CICLOS=10) -> falhas goes 1,2; 3rd attempt -> bloqueado=1 for exactly 10 cycles.
//     valid_in during lockout is dropped; falhas=0 after exit; a correct attempt then passes.
//  T5 wrong, wrong, correct -> falhas returns to 0. A 4th wrong attempt gives falhas=1 and no lockout.
//  T6 rst=0 during BUSCA and during BLOQUEADO -> all outputs 0 at once. The next valid_in is processed normally.
//     Also: valid_in pulsed while busy=1 is ignored.

Source files
------------

// File: rtl/verifica_senha_multi_if.sv
// Handshake/data bundle between the keypad packer, the password checker and the lock FSM.
// Sequences are flat vectors of 4-bit digits; 4'hF terminates a sequence.
interface verifica_senha_multi_if #(
  parameter int MAX_DIG    = 20,
  parameter int NUM_SENHAS = 4,
  parameter int MAX_FALHAS = 3
);
  localparam int IDX_W = (NUM_SENHAS > 1) ? $clog2(NUM_SENHAS) : 1;
  localparam int FW    = $clog2(MAX_FALHAS + 1);

  logic                               valid_in;
  logic [4*MAX_DIG-1:0]               senha_teste;
  logic [NUM_SENHAS*4*MAX_DIG-1:0]    senhas_reais;
  logic [NUM_SENHAS-1:0]              slot_en;
  logic                               busy;
  logic                               done;
  logic                               senha_ok;
  logic [IDX_W-1:0]                   match_idx;
  logic                               bloqueado;
  logic [FW-1:0]                      falhas;

  modport master (
    output valid_in, senha_teste, senhas_reais, slot_en,
    input  busy, done, senha_ok, match_idx, bloqueado, falhas
  );
  modport slave (
    input  valid_in, senha_teste, senhas_reais, slot_en,
    output busy, done, senha_ok, match_idx, bloqueado, falhas
  );
endinterface

// File: rtl/verifica_senha_multi.sv
// Multi-slot password checker: sliding-window search of stored passwords inside the typed
// sequence, one window per cycle, with consecutive-failure counting and timed lockout.
module verifica_senha_multi_lane #(
  parameter int MAX_DIG = 20,
  parameter int K       = 0,
  parameter int LW      = 5
) (
  input  logic [MAX_DIG-1:0][3:0] teste,
  input  logic [LW-1:0]           off,
  input  logic [LW-1:0]           len_s,
  input  logic [3:0]              real_dig,
  output logic                    ok
);
  logic [LW:0] idx;
  logic [3:0]  dig;

  // Out-of-range positions read as terminator; they only occur for lanes beyond len_s.
  always_comb begin
    idx = {1'b0, off} + (LW+1)'(K);
    dig = 4'hF;
    for (int j = 0; j < MAX_DIG; j++)
      if (idx == (LW+1)'(j)) dig = teste[j];
    ok = (len_s <= LW'(K)) || (dig == real_dig);
  end
endmodule

module verifica_senha_multi #(
  parameter int MAX_DIG     = 20,
  parameter int NUM_SENHAS  = 4,
  parameter int MIN_DIG     = 4,
  parameter int MAX_FALHAS  = 3,
  parameter int BLOQ_CICLOS = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  verifica_senha_multi_if.slave bus
);
  localparam int LW = $clog2(MAX_DIG + 1);
  localparam int SW = (NUM_SENHAS > 1) ? $clog2(NUM_SENHAS) : 1;
  localparam int FW = $clog2(MAX_FALHAS + 1);
  localparam int TW = (BLOQ_CICLOS > 1) ? $clog2(BLOQ_CICLOS) : 1;

  typedef enum logic [2:0] {
    IDLE, DIMENSAO, BUSCA, PROXIMA, CORRETA, INCORRETA, BLOQUEADO
  } state_t;

  state_t                                 state;
  logic [MAX_DIG-1:0][3:0]                teste_q;
  logic [NUM_SENHAS-1:0][MAX_DIG-1:0][3:0] reais_q;
  logic [NUM_SENHAS-1:0]                  en_q;
  logic [SW-1:0]                          slot;
  logic [LW-1:0]                          off;
  logic [TW-1:0]                          timer;
  logic [FW-1:0]                          falhas_q;
  logic [SW-1:0]                          match_q;

  function automatic logic [LW-1:0] seq_len(input logic [MAX_DIG-1:0][3:0] d);
    seq_len = LW'(MAX_DIG);
    for (int i = MAX_DIG-1; i >= 0; i--)
      if (d[i] == 4'hF) seq_len = LW'(i);
  endfunction

  logic [MAX_DIG-1:0][3:0] real_cur;
  logic [LW-1:0]           len_t, len_s;
  logic                    slot_ok, win_ok;
  logic [MAX_DIG-1:0]      lane_ok;

  assign real_cur = reais_q[slot];
  assign len_t    = seq_len(teste_q);
  assign len_s    = seq_len(real_cur);
  assign slot_ok  = en_q[slot] && (len_s >= LW'(MIN_DIG)) && (len_s <= len_t);
  assign win_ok   = &lane_ok;

  for (genvar k = 0; k < MAX_DIG; k++) begin : g_lane
    verifica_senha_multi_lane #(.MAX_DIG(MAX_DIG), .K(k), .LW(LW)) u_lane (
      .teste(teste_q), .off(off), .len_s(len_s), .real_dig(real_cur[k]), .ok(lane_ok[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      teste_q  <= '0;
      reais_q  <= '0;
      en_q     <= '0;
      slot     <= '0;
      off      <= '0;
      timer    <= '0;
      falhas_q <= '0;
      match_q  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.valid_in) begin
          teste_q <= bus.senha_teste;
          reais_q <= bus.senhas_reais;
          en_q    <= bus.slot_en;
          slot    <= '0;
          state   <= DIMENSAO;
        end
        DIMENSAO: begin
          off   <= '0;
          state <= slot_ok ? BUSCA : PROXIMA;
        end
        // len_t >= len_s is guaranteed here, so the subtraction cannot wrap.
        BUSCA: begin
          if (win_ok) begin
            match_q <= slot;
            state   <= CORRETA;
          end else if (off < len_t - len_s) begin
            off <= off + 1'b1;
          end else begin
            state <= PROXIMA;
          end
        end
        PROXIMA: begin
          if (slot < SW'(NUM_SENHAS-1)) begin
            slot  <= slot + 1'b1;
            state <= DIMENSAO;
          end else begin
            state <= INCORRETA;
          end
        end
        CORRETA: begin
          falhas_q <= '0;
          state    <= IDLE;
        end
        INCORRETA: begin
          if (falhas_q >= FW'(MAX_FALHAS-1)) begin
            falhas_q <= FW'(MAX_FALHAS);
            timer    <= TW'(BLOQ_CICLOS-1);
            state    <= BLOQUEADO;
          end else begin
            falhas_q <= falhas_q + 1'b1;
            state    <= IDLE;
          end
        end
        BLOQUEADO: begin
          if (timer == '0) begin
            falhas_q <= '0;
            state    <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE) && (state != BLOQUEADO);
  assign bus.done      = (state == CORRETA) || (state == INCORRETA);
  assign bus.senha_ok  = (state == CORRETA);
  assign bus.bloqueado = (state == BLOQUEADO);
  assign bus.match_idx = match_q;
  assign bus.falhas    = falhas_q;
endmodule

// File: tb/tb_verifica_senha_multi.sv
// Scoreboard bench for verifica_senha_multi: stimulus pushes expected verdicts, a monitor
// pops and compares on every done pulse.
module tb_verifica_senha_multi;
  localparam int MD = 20, NS = 4, MF = 3, BC = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0, checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  verifica_senha_multi_if #(.MAX_DIG(MD), .NUM_SENHAS(NS), .MAX_FALHAS(MF)) bus ();
  verifica_senha_multi #(.MAX_DIG(MD), .NUM_SENHAS(NS), .MIN_DIG(4), .MAX_FALHAS(MF),
                         .BLOQ_CICLOS(BC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic ok; int idx; int fal; int lat; int t0; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4*MD-1:0] seq(input string s);
    logic [4*MD-1:0] v;
    v = '1;
    for (int i = 0; i < s.len(); i++) v[4*i +: 4] = 4'(s[i] - 8'h30);
    return v;
  endfunction

  function automatic logic [NS*4*MD-1:0] reais(input string s0, s1, s2, s3);
    return {seq(s3), seq(s2), seq(s1), seq(s0)};
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("senha_ok", int'(bus.senha_ok), int'(mon_e.ok));
        if (mon_e.ok) check("match_idx", int'(bus.match_idx), mon_e.idx);
        check("falhas_at_done", int'(bus.falhas), mon_e.fal);
        check("latency", cyc - mon_e.t0, mon_e.lat);
      end
    end
  end

  task automatic send(input logic [4*MD-1:0] t, input logic [NS*4*MD-1:0] r, input logic [NS-1:0] en,
                      input bit push, input logic ok, input int idx, input int fal, input int lat);
    exp_t e;
    @(negedge clk);
    bus.senha_teste = t; bus.senhas_reais = r; bus.slot_en = en; bus.valid_in = 1'b1;
    if (push) begin
      e.ok = ok; e.idx = idx; e.fal = fal; e.lat = lat; e.t0 = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.done) ok = 1'b1;
    end
    if (!ok) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic correct(input int fal);
    send(seq("1234"), reais("1234", "", "", ""), 4'b0001, 1, 1'b1, 0, fal, 3);
    wait_idle();
  endtask

  // Slot 0 never fits "9999"; slots 1..3 disabled: DIM,BUSCA,PROX then 3x(DIM,PROX), INCORRETA.
  task automatic wrong(input int fal);
    send(seq("9999"), reais("1234", "", "", ""), 4'b0001, 1, 1'b0, 0, fal, 10);
    wait_idle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_ok"}, int'(bus.senha_ok), 0);
    check({tag, "_bloq"}, int'(bus.bloqueado), 0);
    check({tag, "_idx"}, int'(bus.match_idx), 0);
    check({tag, "_falhas"}, int'(bus.falhas), 0);
  endtask

  initial begin
    int n;
    bus.valid_in = 1'b0; bus.senha_teste = '1; bus.senhas_reais = '1; bus.slot_en = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // T1: exact match in slot 0
    correct(0);
    check("t1_falhas", int'(bus.falhas), 0);

    // T2: slot 2 at offset 2 after two full non-matching slot scans (9+9+1+3+1 cycles)
    send(seq("0098765411"), reais("1111", "2222", "987654", ""), 4'b0111, 1, 1'b1, 2, 0, 23);
    wait_idle();

    // T3: short slot 0 skipped, slot 1 matches at offset 0
    send(seq("55555"), reais("123", "5555", "", ""), 4'b0011, 1, 1'b1, 1, 0, 5);
    wait_idle();

    // T4: three failures -> lockout for exactly BC cycles, valid_in dropped meanwhile
    wrong(0); check("t4_falhas1", int'(bus.falhas), 1);
    wrong(1); check("t4_falhas2", int'(bus.falhas), 2);
    wrong(2);
    check("t4_bloq", int'(bus.bloqueado), 1);
    check("t4_falhas_sat", int'(bus.falhas), 3);
    n = 0;
    while (bus.bloqueado && n < 100) begin
      n++;
      if (n == 2) begin
        bus.senha_teste = seq("1234"); bus.senhas_reais = reais("1234", "", "", "");
        bus.slot_en = 4'b0001; bus.valid_in = 1'b1;
      end
      if (n == 3) bus.valid_in = 1'b0;
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    check("t4_lock_cycles", n, BC);
    check("t4_falhas_exit", int'(bus.falhas), 0);
    check("t4_busy_exit", int'(bus.busy), 0);
    correct(0);

    // T5: wrong, wrong, correct clears; a further wrong gives 1 without lockout
    wrong(0); wrong(1); correct(2);
    check("t5_falhas_clr", int'(bus.falhas), 0);
    wrong(0);
    check("t5_falhas1", int'(bus.falhas), 1);
    check("t5_no_bloq", int'(bus.bloqueado), 0);

    // T6a: reset during BUSCA
    send(seq("0098765411"), reais("1111", "2222", "987654", ""), 4'b0111, 0, 1'b0, 0, 0, 0);
    @(negedge clk);
    check("t6_busy_before", int'(bus.busy), 1);
    rst = 1'b0; #1;
    check_zero("t6_busca_rst");
    @(negedge clk); rst = 1'b1;

    // T6b: valid_in while busy ignored; latched operands survive input changes
    send(seq("0098765411"), reais("1111", "2222", "987654", ""), 4'b0111, 1, 1'b1, 2, 0, 23);
    repeat (3) @(negedge clk);
    bus.senha_teste = seq("1234"); bus.senhas_reais = reais("1234", "", "", "");
    bus.slot_en = 4'b0001; bus.valid_in = 1'b1;
    @(negedge clk); bus.valid_in = 1'b0;
    wait_idle();

    // T6c: reset during BLOQUEADO
    wrong(0); wrong(1); wrong(2);
    repeat (3) @(negedge clk);
    check("t6_bloq_before", int'(bus.bloqueado), 1);
    rst = 1'b0; #1;
    check_zero("t6_bloq_rst");
    @(negedge clk); rst = 1'b1;
    correct(0);

    repeat (2) @(negedge clk);
    check("queue_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
